// File: rtl/ras_ctrl_if.sv
// Decode / resolve / RAS signal bundle for the return-address-stack controller.
// The slave modport is the controller; the master modport is its environment.
interface ras_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int PTR_W = 3
);
    logic             dec_valid;
    logic [6:0]       dec_opcode;
    logic [4:0]       dec_rd;
    logic [4:0]       dec_rs1;
    logic [XLEN-1:0]  dec_pc;
    logic [PTR_W-1:0] ras_ptr;
    logic             res_valid;
    logic             res_mispredict;
    logic             ras_push;
    logic             ras_pop;
    logic [XLEN-1:0]  ras_push_addr;
    logic             ras_restore;
    logic [PTR_W-1:0] ras_restore_ptr;
    logic             ckpt_full;
    logic             ckpt_overflow;

    modport slave (
        input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_pc, ras_ptr,
        input  res_valid, res_mispredict,
        output ras_push, ras_pop, ras_push_addr, ras_restore, ras_restore_ptr,
        output ckpt_full, ckpt_overflow
    );

    modport master (
        output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_pc, ras_ptr,
        output res_valid, res_mispredict,
        input  ras_push, ras_pop, ras_push_addr, ras_restore, ras_restore_ptr,
        input  ckpt_full, ckpt_overflow
    );
endinterface

// File: rtl/ras_ctrl.sv
// RAS sequencing: classifies calls/returns/swaps into push/pop strobes, checkpoints
// the stack pointer per in-flight control transfer, restores it on a mispredict.
module ras_ctrl #(
    parameter int XLEN       = 32,
    parameter int PTR_W      = 3,
    parameter int CKPT_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    ras_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(CKPT_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CKPT_DEPTH);
    localparam logic [6:0]       OP_JAL    = 7'b1101111;
    localparam logic [6:0]       OP_JALR   = 7'b1100111;
    localparam logic [6:0]       OP_BRANCH = 7'b1100011;

    typedef enum logic {ST_RUN, ST_RECOVER} state_t;
    state_t state, state_nxt;

    logic [PTR_W-1:0] ckpt_q [CKPT_DEPTH];
    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] restore_ptr;
    logic             overflow;

    logic is_jal, is_jalr, is_ctl, rd_link, rs1_link;
    logic is_call, is_pop;
    logic run, kill, deq, enq, accept, full, full_blocked, ovf_set;

    // Decode classification
    assign is_jal   = bus.dec_opcode == OP_JAL;
    assign is_jalr  = bus.dec_opcode == OP_JALR;
    assign is_ctl   = is_jal || is_jalr || (bus.dec_opcode == OP_BRANCH);
    assign rd_link  = (bus.dec_rd == 5'd1) || (bus.dec_rd == 5'd5);
    assign rs1_link = (bus.dec_rs1 == 5'd1) || (bus.dec_rs1 == 5'd5);
    // A swap is a call that also pops; rd == rs1 link is a plain call.
    assign is_call  = (is_jal || is_jalr) && rd_link;
    assign is_pop   = is_jalr && rs1_link && (!rd_link || (bus.dec_rd != bus.dec_rs1));

    // Resolve side: resolutions with nothing in flight are dropped and flagged.
    assign run          = state == ST_RUN;
    assign kill         = run && bus.res_valid && bus.res_mispredict && (count != '0);
    assign deq          = run && bus.res_valid && !bus.res_mispredict && (count != '0);
    assign full         = count == FULL_CNT;
    assign full_blocked = full && !(bus.res_valid && !bus.res_mispredict);
    assign accept       = bus.dec_valid && run && !kill && !(is_ctl && full_blocked);
    assign enq          = accept && is_ctl;
    assign ovf_set      = run && ((bus.res_valid && (count == '0)) ||
                                  (bus.dec_valid && is_ctl && full_blocked && !kill));

    assign bus.ras_push        = accept && is_call;
    assign bus.ras_pop         = accept && is_pop;
    assign bus.ras_push_addr   = bus.dec_pc + XLEN'(4);
    assign bus.ckpt_full       = full;
    assign bus.ckpt_overflow   = overflow;
    assign bus.ras_restore_ptr = restore_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.ras_restore = 1'b0;
        case (state)
            ST_RUN:     if (kill) state_nxt = ST_RECOVER;
            ST_RECOVER: begin
                bus.ras_restore = 1'b1;
                state_nxt       = ST_RUN;
            end
            default:    state_nxt = ST_RUN;
        endcase
    end

    // Checkpoint storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) ckpt_q[tail] <= bus.ras_ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            restore_ptr <= '0;
            overflow    <= 1'b0;
        end else begin
            if (kill) begin
                restore_ptr <= ckpt_q[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (enq) tail <= tail + IDX_W'(1);
                if (deq) head <= head + IDX_W'(1);
                if (enq && !deq)      count <= count + CNT_W'(1);
                else if (deq && !enq) count <= count - CNT_W'(1);
            end
            if (ovf_set) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: expectations are queued with a due cycle when
// stimulus is driven and compared when that cycle is sampled.
module tb_ras_ctrl;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
    localparam int S_PUSH = 0, S_POP = 1, S_ADDR = 2, S_RST = 3, S_RPTR = 4,
                   S_FULL = 5, S_OVF = 6, S_CNT = 7;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
        int          due;
    } exp_t;
    exp_t sb[$];

    ras_ctrl_if #(.XLEN(32), .PTR_W(3)) bus ();
    ras_ctrl #(.XLEN(32), .PTR_W(3), .CKPT_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs_sig(input int s);
        case (s)
            S_PUSH:  return 32'(bus.ras_push);
            S_POP:   return 32'(bus.ras_pop);
            S_ADDR:  return bus.ras_push_addr;
            S_RST:   return 32'(bus.ras_restore);
            S_RPTR:  return 32'(bus.ras_restore_ptr);
            S_FULL:  return 32'(bus.ckpt_full);
            S_OVF:   return 32'(bus.ckpt_overflow);
            default: return 32'(dut.count);
        endcase
    endfunction

    task automatic expect_at(input string tag, input int sig, input logic [31:0] v, input int dly);
        exp_t e;
        e.tag = tag; e.sig = sig; e.exp = v; e.due = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t keep[$];
        foreach (sb[i]) begin
            if (sb[i].due == cyc) chk(sb[i].tag, obs_sig(sb[i].sig), sb[i].exp);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [31:0] pc, input logic [2:0] ptr,
                       input logic rv, input logic rm);
        bus.dec_valid = v;  bus.dec_opcode = op; bus.dec_rd = rd; bus.dec_rs1 = rs1;
        bus.dec_pc = pc;    bus.ras_ptr = ptr;   bus.res_valid = rv; bus.res_mispredict = rm;
    endtask

    task automatic idle();
        drv(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    endtask

    // Inputs are driven at the falling edge; sampling happens 2 time units later.
    task automatic step();
        #2 check_due();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic branch(input logic [2:0] ptr);
        drv(1'b1, BR, 5'd0, 5'd0, 32'h200, ptr, 1'b0, 1'b0);
        expect_at("br_nopush", S_PUSH, 0, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        expect_at("rst_restore", S_RST, 0, 0);
        expect_at("rst_rptr", S_RPTR, 0, 0);
        expect_at("rst_full", S_FULL, 0, 0);
        expect_at("rst_ovf", S_OVF, 0, 0);
        expect_at("rst_push", S_PUSH, 0, 0);
        expect_at("rst_pop", S_POP, 0, 0);
        step();
        reset = 1'b0;

        // Call, return, swap, rd==rs1 call
        drv(1'b1, JAL, 5'd1, 5'd0, 32'h100, 3'd2, 1'b0, 1'b0);
        expect_at("call_push", S_PUSH, 1, 0);
        expect_at("call_addr", S_ADDR, 32'h104, 0);
        expect_at("call_pop", S_POP, 0, 0);
        expect_at("call_cnt", S_CNT, 1, 1);
        step();
        drv(1'b1, JALR, 5'd0, 5'd1, 32'h300, 3'd3, 1'b0, 1'b0);
        expect_at("ret_pop", S_POP, 1, 0);
        expect_at("ret_push", S_PUSH, 0, 0);
        step();
        drv(1'b1, JALR, 5'd1, 5'd5, 32'hFFFF_FFFC, 3'd2, 1'b0, 1'b0);
        expect_at("swap_push", S_PUSH, 1, 0);
        expect_at("swap_pop", S_POP, 1, 0);
        expect_at("swap_addr", S_ADDR, 32'h0, 0);
        step();
        drv(1'b1, JALR, 5'd5, 5'd5, 32'h400, 3'd3, 1'b0, 1'b0);
        expect_at("same_push", S_PUSH, 1, 0);
        expect_at("same_pop", S_POP, 0, 0);
        step();

        // Resolution with empty queue
        do_reset();
        drv(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0);
        expect_at("empty_ovf", S_OVF, 1, 1);
        step();
        idle();
        step();

        // Mispredict restore
        do_reset();
        branch(3'd3);
        branch(3'd4);
        branch(3'd5);
        drv(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b1);
        expect_at("mp_cnt3", S_CNT, 3, 0);
        expect_at("mp_rst0", S_RST, 0, 0);
        expect_at("mp_rst1", S_RST, 1, 1);
        expect_at("mp_rptr", S_RPTR, 3, 1);
        expect_at("mp_cnt0", S_CNT, 0, 1);
        expect_at("mp_rst_end", S_RST, 0, 2);
        step();
        idle();
        step();
        step();

        // Full queue, fifth transfer blocked
        do_reset();
        for (int i = 0; i < 4; i++) branch(3'(i));
        drv(1'b1, JAL, 5'd1, 5'd0, 32'h500, 3'd4, 1'b0, 1'b0);
        expect_at("full_flag", S_FULL, 1, 0);
        expect_at("full_push", S_PUSH, 0, 0);
        expect_at("full_ovf", S_OVF, 1, 1);
        expect_at("full_cnt", S_CNT, 4, 1);
        step();
        idle();
        step();

        // Full queue with simultaneous dequeue: accepted
        do_reset();
        for (int i = 0; i < 4; i++) branch(3'(i));
        drv(1'b1, JAL, 5'd1, 5'd0, 32'h600, 3'd7, 1'b1, 1'b0);
        expect_at("deq_push", S_PUSH, 1, 0);
        expect_at("deq_addr", S_ADDR, 32'h604, 0);
        expect_at("deq_cnt", S_CNT, 4, 1);
        expect_at("deq_ovf", S_OVF, 0, 1);
        expect_at("deq_full", S_FULL, 1, 1);
        step();
        drv(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b1);
        expect_at("deq_rptr", S_RPTR, 1, 1);
        expect_at("deq_rst", S_RST, 1, 1);
        step();
        idle();
        step();

        // Kill priority and RECOVER suppression
        do_reset();
        branch(3'd6);
        drv(1'b1, JAL, 5'd1, 5'd0, 32'h700, 3'd6, 1'b1, 1'b1);
        expect_at("kill_push", S_PUSH, 0, 0);
        expect_at("kill_cnt", S_CNT, 0, 1);
        expect_at("kill_rst", S_RST, 1, 1);
        expect_at("kill_rptr", S_RPTR, 6, 1);
        step();
        drv(1'b1, JAL, 5'd1, 5'd0, 32'h704, 3'd6, 1'b0, 1'b0);
        expect_at("rec_push", S_PUSH, 0, 0);
        expect_at("rec_cnt", S_CNT, 0, 1);
        expect_at("rec_rst_end", S_RST, 0, 1);
        step();
        idle();
        step();

        // Reset while in RECOVER
        do_reset();
        branch(3'd2);
        drv(1'b0, 7'd0, 5'd0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b1);
        step();
        idle();
        expect_at("mid_rst1", S_RST, 1, 0);
        expect_at("mid_rptr", S_RPTR, 2, 0);
        #2 check_due();
        reset = 1'b1;
        #1;
        chk("mid_async_rst", 32'(bus.ras_restore), 0);
        chk("mid_async_rptr", 32'(bus.ras_restore_ptr), 0);
        @(negedge clk);
        reset = 1'b0;
        expect_at("post_rst0", S_RST, 0, 0);
        expect_at("post_rst1", S_RST, 0, 1);
        expect_at("post_cnt", S_CNT, 0, 1);
        expect_at("post_ovf", S_OVF, 0, 1);
        step();
        step();

        foreach (sb[i]) begin
            miscompares++;
            $display("FAIL %s: got no sample, want 0x%0h at cycle %0d", sb[i].tag, sb[i].exp, sb[i].due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
